// File: rtl/cache_line_filler.sv
// Miss handler for the direct-mapped cache: optional 4-word victim write-back burst,
// then a 4-word line read streamed into the cache data banks and tag RAM.
module cache_line_filler #(
  parameter int ADDRESS_BITWIDTH = 32,
  parameter int LINE_IX_BITWIDTH = 10,
  parameter int TAG_BITWIDTH     = ADDRESS_BITWIDTH - LINE_IX_BITWIDTH - 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDRESS_BITWIDTH-1:0]   req_addr,
  input  logic                          req_dirty,
  input  logic [ADDRESS_BITWIDTH-1:0]   victim_addr,
  input  logic [127:0]                  victim_data,
  output logic                          mem_cmd_valid,
  input  logic                          mem_cmd_ready,
  output logic                          mem_cmd_write,
  output logic [ADDRESS_BITWIDTH-1:0]   mem_cmd_addr,
  output logic [31:0]                   mem_wdata,
  output logic                          mem_wdata_valid,
  input  logic                          mem_wdata_ready,
  input  logic [31:0]                   mem_rdata,
  input  logic                          mem_rdata_valid,
  output logic                          fill_we,
  output logic [1:0]                    fill_word_ix,
  output logic [31:0]                   fill_data,
  output logic [LINE_IX_BITWIDTH-1:0]   fill_line_ix,
  output logic [TAG_BITWIDTH-1:0]       fill_tag,
  output logic                          fill_tag_we,
  output logic                          done
);

  localparam int LA_W = ADDRESS_BITWIDTH - 4;

  typedef enum logic [2:0] {
    IDLE, WB_CMD, WB_DATA, RD_CMD, RD_DATA, DONE
  } state_t;

  state_t             state_q;
  logic [1:0]         cnt_q;
  logic [1:0]         cnt_d;
  logic [LA_W-1:0]    line_addr_q;
  logic [3:0][31:0]   victim_q;
  logic               req_ready_q;
  logic               cmd_valid_q;
  logic               cmd_write_q;
  logic [LA_W-1:0]    cmd_line_q;
  logic [31:0]        wdata_q;
  logic               wdata_valid_q;
  logic               done_q;
  logic               rd_take;

  // Byte/word offset bits of both addresses are don't-care; bursts are line aligned.
  logic unused_offsets;
  assign unused_offsets = ^{req_addr[3:0], victim_addr[3:0]};

  assign cnt_d   = cnt_q + 2'd1;
  assign rd_take = (state_q == RD_DATA) && mem_rdata_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      line_addr_q   <= '0;
      victim_q      <= '0;
      req_ready_q   <= 1'b1;
      cmd_valid_q   <= 1'b0;
      cmd_write_q   <= 1'b0;
      cmd_line_q    <= '0;
      wdata_q       <= '0;
      wdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            line_addr_q <= req_addr[ADDRESS_BITWIDTH-1:4];
            victim_q    <= victim_data;
            cnt_q       <= 2'd0;
            cmd_valid_q <= 1'b1;
            if (req_dirty) begin
              state_q     <= WB_CMD;
              cmd_write_q <= 1'b1;
              cmd_line_q  <= victim_addr[ADDRESS_BITWIDTH-1:4];
            end else begin
              state_q     <= RD_CMD;
              cmd_write_q <= 1'b0;
              cmd_line_q  <= req_addr[ADDRESS_BITWIDTH-1:4];
            end
          end
        end
        WB_CMD: begin
          if (mem_cmd_ready) begin
            cmd_valid_q   <= 1'b0;
            wdata_valid_q <= 1'b1;
            wdata_q       <= victim_q[0];
            state_q       <= WB_DATA;
          end
        end
        WB_DATA: begin
          if (mem_wdata_ready) begin
            cnt_q <= cnt_d;
            if (cnt_q == 2'd3) begin
              // Write-back drained: the read command follows directly.
              wdata_valid_q <= 1'b0;
              cmd_valid_q   <= 1'b1;
              cmd_write_q   <= 1'b0;
              cmd_line_q    <= line_addr_q;
              state_q       <= RD_CMD;
            end else begin
              wdata_q <= victim_q[cnt_d];
            end
          end
        end
        RD_CMD: begin
          if (mem_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            cnt_q       <= 2'd0;
            state_q     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (mem_rdata_valid) begin
            cnt_q <= cnt_d;
            if (cnt_q == 2'd3) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready       = req_ready_q;
  assign mem_cmd_valid   = cmd_valid_q;
  assign mem_cmd_write   = cmd_write_q;
  assign mem_cmd_addr    = {cmd_line_q, 4'b0000};
  assign mem_wdata       = wdata_q;
  assign mem_wdata_valid = wdata_valid_q;
  assign done            = done_q;

  // Read data has no back-pressure, so fill strobes follow rdata_valid combinationally.
  assign fill_we      = rd_take;
  assign fill_word_ix = cnt_q;
  assign fill_data    = rd_take ? mem_rdata : 32'd0;
  assign fill_tag_we  = rd_take && (cnt_q == 2'd3);
  assign fill_line_ix = line_addr_q[LINE_IX_BITWIDTH-1:0];
  assign fill_tag     = line_addr_q[LA_W-1:LINE_IX_BITWIDTH];

endmodule
